// File: rtl/ysyx_24090013_regfile_if.sv
// Decode read ports, write-back handshake and buffer status shared by the
// register file and the pipeline stages around it.
interface ysyx_24090013_regfile_if #(
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 2
);
  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

  logic              id_reg_rs1_ren;
  logic [4:0]        id_reg_rs1_addr;
  logic [DATA_W-1:0] reg_id_rs1_data;
  logic              id_reg_rs2_ren;
  logic [4:0]        id_reg_rs2_addr;
  logic [DATA_W-1:0] reg_id_rs2_data;
  logic              wb_reg_rd_valid;
  logic              wb_reg_rd_ready;
  logic [4:0]        wb_reg_rd_addr;
  logic [DATA_W-1:0] wb_reg_rd_data;
  logic              reg_commit_en;
  logic [CNT_W-1:0]  reg_wbuf_count;

  modport master (
    output id_reg_rs1_ren, id_reg_rs1_addr, id_reg_rs2_ren, id_reg_rs2_addr,
    output wb_reg_rd_valid, wb_reg_rd_addr, wb_reg_rd_data, reg_commit_en,
    input  reg_id_rs1_data, reg_id_rs2_data, wb_reg_rd_ready, reg_wbuf_count
  );

  modport slave (
    input  id_reg_rs1_ren, id_reg_rs1_addr, id_reg_rs2_ren, id_reg_rs2_addr,
    input  wb_reg_rd_valid, wb_reg_rd_addr, wb_reg_rd_data, reg_commit_en,
    output reg_id_rs1_data, reg_id_rs2_data, wb_reg_rd_ready, reg_wbuf_count
  );
endinterface

// File: rtl/ysyx_24090013_regfile.sv
// RV32 register file: 32x32 array fed by an in-order write buffer, with
// youngest-first forwarding of pending writes to both read ports.
module ysyx_24090013_regfile #(
  parameter int WBUF_DEPTH = 2,
  parameter int DATA_W     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  ysyx_24090013_regfile_if.slave    bus
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WBUF_DEPTH);

  logic [DATA_W-1:0]                   regs_q [32];
  logic [WBUF_DEPTH-1:0][4:0]          wb_addr_q;
  logic [WBUF_DEPTH-1:0][DATA_W-1:0]   wb_data_q;
  logic [WBUF_DEPTH-1:0]               wb_vld_q, wb_vld_d;
  logic [PTR_W-1:0]                    head_q, head_d;
  logic [PTR_W-1:0]                    tail_q, tail_d;
  logic [CNT_W-1:0]                    count_q, count_d;

  logic wr_ready;
  logic wr_accept;
  logic enq;
  logic deq;

  // Scan from oldest (head) to youngest so the last match wins, independent of wrap.
  function automatic logic [DATA_W-1:0] fwd_lookup(
    input logic                              ren,
    input logic [4:0]                        addr,
    input logic [PTR_W-1:0]                  head,
    input logic [WBUF_DEPTH-1:0]             vld,
    input logic [WBUF_DEPTH-1:0][4:0]        addrs,
    input logic [WBUF_DEPTH-1:0][DATA_W-1:0] datas,
    input logic [DATA_W-1:0]                 arr_val
  );
    logic [DATA_W-1:0] res;
    logic [PTR_W-1:0]  idx;
    res = arr_val;
    idx = head;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (vld[idx] && (addrs[idx] == addr)) begin
        res = datas[idx];
      end
    end
    if (!ren || (addr == 5'd0)) begin
      res = {DATA_W{1'b0}};
    end
    return res;
  endfunction

  assign wr_ready  = (count_q != DEPTH_C);
  assign wr_accept = bus.wb_reg_rd_valid & wr_ready;
  assign enq       = wr_accept & (bus.wb_reg_rd_addr != 5'd0);
  assign deq       = (count_q != {CNT_W{1'b0}}) & bus.reg_commit_en;

  assign bus.wb_reg_rd_ready = wr_ready;
  assign bus.reg_wbuf_count  = count_q;
  assign bus.reg_id_rs1_data = fwd_lookup(bus.id_reg_rs1_ren, bus.id_reg_rs1_addr, head_q,
                                          wb_vld_q, wb_addr_q, wb_data_q,
                                          regs_q[bus.id_reg_rs1_addr]);
  assign bus.reg_id_rs2_data = fwd_lookup(bus.id_reg_rs2_ren, bus.id_reg_rs2_addr, head_q,
                                          wb_vld_q, wb_addr_q, wb_data_q,
                                          regs_q[bus.id_reg_rs2_addr]);

  // Next-state for pointers, occupancy and per-slot valid bits.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    wb_vld_d = wb_vld_q;
    count_d  = count_q + {{(CNT_W-1){1'b0}}, enq} - {{(CNT_W-1){1'b0}}, deq};
    if (deq) begin
      head_d           = head_q + {{(PTR_W-1){1'b0}}, 1'b1};
      wb_vld_d[head_q] = 1'b0;
    end else begin
      head_d = head_q;
    end
    if (enq) begin
      tail_d           = tail_q + {{(PTR_W-1){1'b0}}, 1'b1};
      wb_vld_d[tail_q] = 1'b1;
    end else begin
      tail_d = tail_q;
    end
  end

  // Buffer control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q   <= {PTR_W{1'b0}};
      tail_q   <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      wb_vld_q <= {WBUF_DEPTH{1'b0}};
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wb_vld_q <= wb_vld_d;
    end
  end

  // Buffer payload, written at tail on enqueue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_addr_q <= '{default: 5'd0};
      wb_data_q <= '{default: {DATA_W{1'b0}}};
    end else if (enq) begin
      wb_addr_q[tail_q] <= bus.wb_reg_rd_addr;
      wb_data_q[tail_q] <= bus.wb_reg_rd_data;
    end else begin
      wb_addr_q <= wb_addr_q;
      wb_data_q <= wb_data_q;
    end
  end

  // Architectural array, updated only by the committing head entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (deq) begin
      regs_q[wb_addr_q[head_q]] <= wb_data_q[head_q];
    end else begin
      regs_q <= regs_q;
    end
  end
endmodule

// File: tb/tb_ysyx_24090013_regfile.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's
// outputs; a monitor process pops and compares them against the DUT.
module tb_ysyx_24090013_regfile;
  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ysyx_24090013_regfile_if #(.DATA_W(32), .WBUF_DEPTH(DEPTH)) bus ();
  ysyx_24090013_regfile #(.WBUF_DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [31:0] rs1; logic [31:0] rs2; logic ready; logic [CNT_W-1:0] count; } exp_t;

  logic [31:0] m_arr [32];
  wr_t         m_q [$];
  exp_t        sb_q [$];
  event        mon_ev;
  int          checks = 0;
  int          errors = 0;
  logic        tog = 1'b0;

  function automatic logic [31:0] m_read(input logic ren, input logic [4:0] addr);
    if (!ren || addr == 5'd0) return 32'd0;
    for (int i = m_q.size() - 1; i >= 0; i--)
      if (m_q[i].a == addr) return m_q[i].d;
    return m_arr[addr];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_expect(input logic r1en, input logic [4:0] r1a,
                             input logic r2en, input logic [4:0] r2a);
    exp_t e;
    e.rs1   = m_read(r1en, r1a);
    e.rs2   = m_read(r2en, r2a);
    e.ready = (m_q.size() != DEPTH);
    e.count = CNT_W'(m_q.size());
    sb_q.push_back(e);
    ->mon_ev;
  endtask

  // One clock cycle: drive, predict, then advance the model at the edge.
  task automatic drive(input logic r1en, input logic [4:0] r1a,
                       input logic r2en, input logic [4:0] r2a,
                       input logic v, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ce, output logic acc);
    @(negedge clk);
    bus.id_reg_rs1_ren  = r1en; bus.id_reg_rs1_addr = r1a;
    bus.id_reg_rs2_ren  = r2en; bus.id_reg_rs2_addr = r2a;
    bus.wb_reg_rd_valid = v;    bus.wb_reg_rd_addr  = wa;
    bus.wb_reg_rd_data  = wd;   bus.reg_commit_en   = ce;
    #1;
    acc = v && (m_q.size() != DEPTH);
    push_expect(r1en, r1a, r2en, r2a);
    @(posedge clk);
    if (m_q.size() != 0 && ce) begin
      m_arr[m_q[0].a] = m_q[0].d;
      void'(m_q.pop_front());
    end
    if (acc && wa != 5'd0) m_q.push_back('{a: wa, d: wd});
  endtask

  task automatic idle(input logic [4:0] r1a, input logic [4:0] r2a, input logic ce);
    logic acc;
    drive(1'b1, r1a, 1'b1, r2a, 1'b0, 5'd0, 32'd0, ce, acc);
  endtask

  // ce_kind: 0 off, 1 on, 2 toggling every cycle. Holds valid until accepted.
  task automatic send_hold(input logic [4:0] wa, input logic [31:0] wd, input int ce_kind);
    logic acc, ce;
    int   budget;
    acc = 1'b0;
    budget = 20;
    while (!acc && budget > 0) begin
      ce = (ce_kind == 2) ? tog : (ce_kind == 1);
      tog = ~tog;
      drive(1'b1, wa, 1'b1, 5'($urandom_range(31, 0)), 1'b1, wa, wd, ce, acc);
      budget--;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset_midstream();
    @(negedge clk);
    reset = 1'b0;
    bus.wb_reg_rd_valid = 1'b0; bus.reg_commit_en = 1'b0;
    bus.id_reg_rs1_ren = 1'b1; bus.id_reg_rs1_addr = 5'd9;
    bus.id_reg_rs2_ren = 1'b1; bus.id_reg_rs2_addr = 5'd10;
    for (int i = 0; i < 32; i++) m_arr[i] = 32'd0;
    m_q.delete();
    #1;
    push_expect(1'b1, 5'd9, 1'b1, 5'd10);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain_and_dump();
    int budget;
    budget = 20;
    while (m_q.size() != 0 && budget > 0) begin
      idle(5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)), 1'b1);
      budget--;
    end
    for (int i = 0; i < 16; i++) idle(5'(2 * i), 5'(2 * i + 1), 1'b0);
  endtask

  // Monitor: pops one prediction per driven cycle and compares it.
  initial begin
    exp_t e;
    forever begin
      @(mon_ev);
      #1;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("rs1_data", bus.reg_id_rs1_data, e.rs1);
        check("rs2_data", bus.reg_id_rs2_data, e.rs2);
        check("ready", {31'd0, bus.wb_reg_rd_ready}, {31'd0, e.ready});
        check("count", 32'(bus.reg_wbuf_count), 32'(e.count));
      end
    end
  end

  initial begin
    logic acc;
    reset = 1'b0;
    bus.id_reg_rs1_ren = 1'b0; bus.id_reg_rs1_addr = 5'd0;
    bus.id_reg_rs2_ren = 1'b0; bus.id_reg_rs2_addr = 5'd0;
    bus.wb_reg_rd_valid = 1'b0; bus.wb_reg_rd_addr = 5'd0;
    bus.wb_reg_rd_data = 32'd0; bus.reg_commit_en = 1'b0;
    for (int i = 0; i < 32; i++) m_arr[i] = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) idle(5'(2 * i), 5'(2 * i + 1), 1'b0);

    // Basic write then read, and disabled read ports.
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 32'h12345678, 1'b1, acc);
    repeat (3) idle(5'd5, 5'd5, 1'b1);
    drive(1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 5'd0, 32'd0, 1'b1, acc);

    // Youngest pending write wins while the buffer drains.
    send_hold(5'd7, 32'h1, 0);
    send_hold(5'd7, 32'h2, 0);
    idle(5'd7, 5'd7, 1'b0);
    repeat (3) idle(5'd7, 5'd7, 1'b1);

    // Reset with two writes pending, then x0 write.
    send_hold(5'd9, 32'h99, 0);
    send_hold(5'd10, 32'hAA, 0);
    do_reset_midstream();
    idle(5'd9, 5'd10, 1'b0);
    drive(1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, acc);
    idle(5'd0, 5'd5, 1'b0);

    // Full backpressure: x6 stalls until a drain frees a slot.
    send_hold(5'd3, 32'hA, 0);
    send_hold(5'd4, 32'hB, 0);
    drive(1'b1, 5'd6, 1'b1, 5'd3, 1'b1, 5'd6, 32'hC, 1'b0, acc);
    drive(1'b1, 5'd6, 1'b1, 5'd4, 1'b1, 5'd6, 32'hC, 1'b1, acc);
    drive(1'b1, 5'd6, 1'b1, 5'd3, 1'b1, 5'd6, 32'hC, 1'b0, acc);
    drain_and_dump();

    // Wrap-around stream with commit toggling.
    for (int i = 1; i <= 10; i++) send_hold(5'(i), 32'(i * 32'h11), 2);
    drain_and_dump();

    // Concurrent enqueue and drain at occupancy 1.
    send_hold(5'd12, 32'hC0C0, 0);
    for (int i = 0; i < 8; i++)
      drive(1'b1, 5'(13 + i), 1'b1, 5'(12 + i), 1'b1, 5'(13 + i), $urandom, 1'b1, acc);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(1, 0) != 0, 5'($urandom_range(31, 0)),
            $urandom_range(3, 0) != 0, 5'($urandom_range(7, 0)),
            $urandom_range(1, 0) != 0, 5'($urandom_range(7, 0)), $urandom,
            $urandom_range(2, 0) != 0, acc);
    drain_and_dump();

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
